seg7_multi_display: RTL
=======================

// Module: seg7_multi_display
// PURPOSE
//  Multi-digit 7-segment display driver: accepts a binary value on a load strobe and
//  converts it to BCD (iterative double-dabble, one bit per clock) or to hex nibbles.
//  Registers DIGITS active-low glyphs with leading-zero blanking, overflow dashes and
//  a blink mode. Sits between datapath counters and the board HEX outputs.
// PARAMETERS
//  DIGITS     6         number of display digits (1..8)
//  BIN_W      20        width of binary input value (1..32)
//  BLINK_DIV  25000000  clock cycles per blink half-period (>=1)
// PORTS
//  clk        in   1          single system clock, all logic on rising edge
//  reset      in   1          synchronous, active-low reset
//  value      in   BIN_W      binary value to display, sampled on accepted load
//  load       in   1          request to convert/display value; accepted only when busy=0
//  hex_mode   in   1          sampled with load: 1=hex digits, 0=decimal
//  blank_lz   in   1          sampled with load: 1=blank leading zeros
//  blink_en   in   1          live (not sampled): 1=all digits blank in off phase
//  busy       out  1          conversion in progress; load ignored
//  done       out  1          one-cycle pulse, display registers just updated
//  overflow   out  1          last committed value did not fit DIGITS digits
//  leds       out  7*DIGITS   digit i glyph at leds[7*i+6:7*i], bit6..0 = seg g..a, active-low
// BEHAVIOUR
//  Reset (reset==0 at edge): state IDLE, busy=0, done=0, overflow=0, all glyphs 7'h7F
//   (blank), blink counter=0, phase=on. Applies mid-conversion; partial result discarded.
//  FSM IDLE->CONV->COMMIT->IDLE (decimal); IDLE->COMMIT->IDLE (hex).
//  IDLE: load=1 at edge T captures value/hex_mode/blank_lz; busy=1 from T.
//  CONV: BIN_W edges, each one shift-add-3 step over a (4*DIGITS+4)-bit BCD scratch;
//   the extra top digit detects overflow. Leaves after shift BIN_W.
//  COMMIT: one edge writes glyph registers, overflow; busy=0, done=1 for the next cycle.
//  Latency load->leds: decimal BIN_W+2 edges (commit at T+BIN_W+1); hex 2 edges (T+1).
//  load while busy=1 is ignored, not queued. load held high re-accepts in first IDLE cycle.
//  Glyphs: 0-9 standard; A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110;
//   blank=1111111; dash=0111111.
//  Overflow decimal: value > 10^DIGITS-1. Overflow hex: any value bit >= 4*DIGITS set.
//   On overflow all digits show dash; overflow=1 until next commit.
//  Leading-zero blanking: digits above the most significant nonzero digit blank; digit 0
//   always shown (value 0 -> single "0"). Not applied when overflow.
//  Blink: counter counts 0..BLINK_DIV-1, toggles phase on wrap, free-running from reset.
//   leds = all blank when blink_en=1 and phase=off; else committed glyphs. Combinational
//   mask on registered glyphs; no effect on busy/done.
//  Widths: scratch arithmetic unsigned; add-3 applied per digit when digit >= 5 before shift.
// STRUCTURE
//  seg7_pkg: glyph constants (GLYPH_BLANK, GLYPH_DASH), state enum typedef,
//   function glyph_of(logic [3:0]) -> logic [6:0] covering 0-F.
//  Sub-module seg7_glyph (nibble, blank -> 7-bit active-low glyph), instantiated DIGITS
//   times in a generate loop at commit input.
//  Top: FSM, shift counter, BCD scratch, glyph regs, blink counter.
// TESTING
//  1 Reset then idle: leds all 7'h7F, busy=0, done=0, overflow=0.
//  2 DIGITS=6,BIN_W=20, load 123456 dec, blank_lz=0: busy 21 cycles, done pulse,
//    leds HEX5..0 = 1,2,3,4,5,6 glyphs; done exactly 1 cycle.
//  3 load 42 dec, blank_lz=1 -> HEX1=4 (0011001), HEX0=2 (0100100), HEX5..2 blank;
//    load 0 -> only HEX0=1000000.
//  4 load 1000000 dec -> overflow=1, all six digits 0111111; then load 7 -> overflow=0.
//  5 hex_mode=1, load 20'hABC0F -> done after 1 cycle, HEX4..0 = A,b,C,0,F, HEX5=0.
//  6 load during CONV ignored (result equals first value); reset asserted mid-CONV
//    -> next cycle blank, busy=0; BLINK_DIV=4 with blink_en=1 -> leds blank 4 cycles
//    of every 8.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants, FSM state type and the nibble-to-glyph table.
// Glyphs are active-low with bit6..0 = segments g..a.
package seg7_pkg;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    function automatic logic [6:0] glyph_of(input logic [3:0] n);
        case (n)
            4'h0:    glyph_of = 7'h40;
            4'h1:    glyph_of = 7'h79;
            4'h2:    glyph_of = 7'h24;
            4'h3:    glyph_of = 7'h30;
            4'h4:    glyph_of = 7'h19;
            4'h5:    glyph_of = 7'h12;
            4'h6:    glyph_of = 7'h02;
            4'h7:    glyph_of = 7'h78;
            4'h8:    glyph_of = 7'h00;
            4'h9:    glyph_of = 7'h10;
            4'hA:    glyph_of = 7'h08;
            4'hB:    glyph_of = 7'h03;
            4'hC:    glyph_of = 7'h46;
            4'hD:    glyph_of = 7'h21;
            4'hE:    glyph_of = 7'h06;
            default: glyph_of = 7'h0E;
        endcase
    endfunction
endpackage

// File: rtl/seg7_multi_display_glyph.sv
// seg7_glyph: one digit's nibble to active-low 7-segment glyph, or blank.
//   i_nibble  digit value 0..F
//   i_blank   1 forces the blank glyph
//   o_glyph   active-low segments g..a
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_glyph
);
    assign o_glyph = i_blank ? GLYPH_BLANK : glyph_of(i_nibble);
endmodule

// File: rtl/seg7_multi_display.sv
// seg7_multi_display: binary value to multi-digit 7-segment glyphs, decimal (serial
// double-dabble) or hex, with leading-zero blanking, overflow dashes and blink.
//   i_clk       system clock, rising edge
//   i_reset     synchronous, active-low reset
//   i_value     binary value, captured on an accepted load
//   i_load      convert request, accepted only while not busy
//   i_hex_mode  captured with load: 1 = hex digits, 0 = decimal
//   i_blank_lz  captured with load: 1 = blank leading zeros
//   i_blink_en  live: 1 = blank all digits during the blink off phase
//   o_busy      conversion in progress, load ignored
//   o_done      one-cycle pulse after the glyph registers update
//   o_overflow  last committed value did not fit DIGITS digits
//   o_leds      digit i glyph at o_leds[7*i+6:7*i], active-low g..a
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int BIN_W     = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [BIN_W-1:0]      i_value,
    input  logic                  i_load,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    input  logic                  i_blink_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [7*DIGITS-1:0]   o_leds
);
    localparam int DW = 4*DIGITS;
    localparam int SW = DW + 4;
    localparam int CW = $clog2(BIN_W+1);
    localparam int BW = $clog2(BLINK_DIV+1);

    state_t              r_state;
    logic [BIN_W-1:0]    r_bin;
    logic [SW-1:0]       r_bcd;
    logic [CW-1:0]       r_cnt;
    logic [BW-1:0]       r_blink_cnt;
    logic [7*DIGITS-1:0] r_glyph;
    logic                r_lost, r_hex, r_blz, r_busy, r_done, r_ovf, r_phase_off;
    logic [SW-1:0]       w_adj;
    logic [DW-1:0]       w_hex, w_digits;
    logic [DIGITS-1:0]   w_blank;
    logic [7*DIGITS-1:0] w_glyph;
    logic                w_ovf, w_wrap;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS+1; k++)
            w_adj[4*k+:4] = r_bcd[4*k+:4] >= 4'd5 ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
    end

    assign w_hex    = DW'(r_bin);
    assign w_digits = r_hex ? w_hex : r_bcd[DW-1:0];
    // r_lost catches digits carried beyond even the spare top digit (wide BIN_W, few DIGITS)
    assign w_ovf    = r_hex ? ((r_bin >> DW) != '0) : (r_lost || r_bcd[SW-1 -: 4] != 4'd0);
    assign w_wrap   = r_blink_cnt == BW'(BLINK_DIV-1);

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        // blank when every digit from i upward is zero; digit 0 is always shown
        assign w_blank[i] = r_blz && (i > 0) && ((w_digits >> (4*i)) == '0);
        seg7_glyph u_glyph (
            .i_nibble (w_digits[4*i+:4]),
            .i_blank  (w_blank[i]),
            .o_glyph  (w_glyph[7*i+:7])
        );
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_lost      <= 1'b0;
            r_hex       <= 1'b0;
            r_blz       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_glyph     <= {DIGITS{GLYPH_BLANK}};
            r_blink_cnt <= '0;
            r_phase_off <= 1'b0;
        end else begin
            r_blink_cnt <= w_wrap ? '0 : r_blink_cnt + 1'b1;
            if (w_wrap)
                r_phase_off <= ~r_phase_off;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_load) begin
                    r_bin   <= i_value;
                    r_hex   <= i_hex_mode;
                    r_blz   <= i_blank_lz;
                    r_bcd   <= '0;
                    r_lost  <= 1'b0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= i_hex_mode ? S_COMMIT : S_CONV;
                end
                S_CONV: begin
                    r_bcd  <= {w_adj[SW-2:0], r_bin[BIN_W-1]};
                    r_lost <= r_lost | w_adj[SW-1];
                    r_bin  <= r_bin << 1;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(BIN_W-1))
                        r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_glyph <= w_ovf ? {DIGITS{GLYPH_DASH}} : w_glyph;
                    r_ovf   <= w_ovf;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_overflow = r_ovf;
    assign o_leds     = (i_blink_en && r_phase_off) ? {DIGITS{GLYPH_BLANK}} : r_glyph;
endmodule
